bcd_display_arbiter: RTL and testbench

- Shares one multiplexed 7-segment display (driven by bcd_mux) between REQ_NUM independent BCD data sources, e.g. counter, clock and status message.
- Round-robin arbitration with a minimum hold time per owner, so the display does not flicker between sources.
- Inserts a blanking interval on every owner change.
- Sits directly upstream of bcd_mux: o_bcd_data feeds bcd_mux i_bcd_data.

---
 rtl/bcd_display_arbiter_pkg.sv | 23 ++
 rtl/bcd_display_arbiter_rr_picker.sv | 35 +++
 rtl/bcd_display_arbiter.sv | 150 +++++++++++++++
 tb/tb_bcd_display_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_arbiter_pkg.sv
// Shared definitions for the BCD display arbiter: FSM encoding, the blank digit
// code and the clogb2 width helper.
package bcd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clogb2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bcd_display_arbiter_rr_picker.sv
// Combinational round-robin search: the first requester found after i_ptr,
// wrapping modulo N, is reported as an index and as a one-hot vector.
module rr_picker
    import bcd_arb_pkg::*;
#(
    parameter  int N  = 3,
    localparam int PW = clogb2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic          o_any,
    output logic [PW-1:0] o_idx,
    output logic [N-1:0]  o_onehot
);

    int w_pos;

    // NOTE: every output gets a default before the loop, otherwise paths that
    // find no requester would hold the old value and infer a latch.
    always_comb begin
        o_any    = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_pos    = 0;
        for (int k = 1; k <= N; k++) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_pos]) begin
                o_any           = 1'b1;
                o_idx           = PW'(w_pos);
                o_onehot[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_display_arbiter.sv
// Round-robin owner selection for one multiplexed 7-segment display, with a
// minimum hold per owner and a forced blank between owners.
// Optional macro BCD_ARB_PRIORITY_EN: source 0 preempts and always wins selection.
module bcd_display_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int REQ_NUM         = 3,
    parameter int DISPLAYS_NUM    = 4,
    parameter int HOLD_CLK_COUNT  = 1000,
    parameter int BLANK_CLK_COUNT = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [REQ_NUM-1:0]                i_req,
    input  logic [REQ_NUM*DISPLAYS_NUM*4-1:0] i_bcd_data,
    output logic [DISPLAYS_NUM*4-1:0]         o_bcd_data,
    output logic [REQ_NUM-1:0]                o_grant,
    output logic                              o_valid,
    output logic                              o_busy
);

    localparam int FW = DISPLAYS_NUM * 4;
    localparam int PW = clogb2(REQ_NUM);
    localparam int HW = clogb2(HOLD_CLK_COUNT);
    localparam int BW = clogb2(BLANK_CLK_COUNT);

    localparam logic [FW-1:0] BLANK_FRAME = {DISPLAYS_NUM{BLANK_CODE}};
    localparam logic [PW-1:0] PTR_INIT    = PW'(REQ_NUM - 1);
    localparam logic [HW-1:0] HOLD_LOAD   = HW'(HOLD_CLK_COUNT - 1);
    localparam logic [BW-1:0] BLANK_LOAD  = BW'(BLANK_CLK_COUNT - 1);

    state_t               r_state;
    logic [PW-1:0]        r_ptr;
    logic [HW-1:0]        r_hold;
    logic [BW-1:0]        r_blank;
    logic [REQ_NUM-1:0]   r_grant;
    logic [FW-1:0]        r_bcd_data;
    logic                 r_valid;
    logic                 r_busy;

    logic                 w_pick_any;
    logic [PW-1:0]        w_pick_idx;
    logic [REQ_NUM-1:0]   w_pick_onehot;
    logic [PW-1:0]        w_win_idx;
    logic [REQ_NUM-1:0]   w_win_onehot;
    logic                 w_urgent;
    logic                 w_owner_req;
    logic                 w_other_req;
    logic                 w_leave_grant;
    logic [FW-1:0]        w_owner_frame;

    rr_picker #(.N(REQ_NUM)) u_rr_picker (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_any    (w_pick_any),
        .o_idx    (w_pick_idx),
        .o_onehot (w_pick_onehot)
    );

`ifdef BCD_ARB_PRIORITY_EN
    assign w_win_idx    = i_req[0] ? '0 : w_pick_idx;
    assign w_win_onehot = i_req[0] ? {{(REQ_NUM-1){1'b0}}, 1'b1} : w_pick_onehot;
    assign w_urgent     = i_req[0] & ~r_grant[0];
`else
    assign w_win_idx    = w_pick_idx;
    assign w_win_onehot = w_pick_onehot;
    assign w_urgent     = 1'b0;
`endif

    assign w_owner_req   = |(i_req & r_grant);
    assign w_other_req   = |(i_req & ~r_grant);
    // Hold only guards against preemption; an owner may always let go early.
    assign w_leave_grant = !w_owner_req || ((r_hold == '0) && w_other_req) || w_urgent;

    always_comb begin
        w_owner_frame = BLANK_FRAME;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (r_ptr == PW'(k)) begin
                w_owner_frame = i_bcd_data[k*FW +: FW];
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples values from before the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= PTR_INIT;
            r_hold     <= '0;
            r_blank    <= '0;
            r_grant    <= '0;
            r_bcd_data <= BLANK_FRAME;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_state <= ST_GRANT;
                        r_grant <= w_win_onehot;
                        r_ptr   <= w_win_idx;
                        r_hold  <= HOLD_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_leave_grant) begin
                        r_state    <= ST_BLANK;
                        r_grant    <= '0;
                        r_bcd_data <= BLANK_FRAME;
                        r_valid    <= 1'b0;
                        r_blank    <= BLANK_LOAD;
                    end else begin
                        r_bcd_data <= w_owner_frame;
                        r_valid    <= 1'b1;
                        if (r_hold != '0) begin
                            r_hold <= r_hold - 1'b1;
                        end
                    end
                end
                ST_BLANK: begin
                    if (r_blank != '0) begin
                        r_blank <= r_blank - 1'b1;
                    end else if (w_pick_any) begin
                        r_state <= ST_GRANT;
                        r_grant <= w_win_onehot;
                        r_ptr   <= w_win_idx;
                        r_hold  <= HOLD_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_bcd_data = r_bcd_data;
    assign o_grant    = r_grant;
    assign o_valid    = r_valid;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_bcd_display_arbiter.sv
// Directed bench for bcd_display_arbiter with HOLD=8 and BLANK=2; source k
// presents 16'h1111*(k+1).
module tb_bcd_display_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic [2:0]  i_req;
    logic [47:0] i_bcd_data;
    logic [15:0] o_bcd_data;
    logic [2:0]  o_grant;
    logic        o_valid;
    logic        o_busy;

    int n_tests;
    int n_fail;

    bcd_display_arbiter #(
        .REQ_NUM         (3),
        .DISPLAYS_NUM    (4),
        .HOLD_CLK_COUNT  (8),
        .BLANK_CLK_COUNT (2)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .i_bcd_data (i_bcd_data),
        .o_bcd_data (o_bcd_data),
        .o_grant    (o_grant),
        .o_valid    (o_valid),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    logic [2:0] rr_seq [4];

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        i_bcd_data = {16'h3333, 16'h2222, 16'h1111};
`ifdef BCD_ARB_PRIORITY_EN
        rr_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
        rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif

        // Reset held with all sources requesting.
        i_rst = 1'b1;
        i_req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_grant", 16'(o_grant), 16'h0000);
            check("rst_valid", 16'(o_valid), 16'h0000);
            check("rst_busy",  16'(o_busy),  16'h0000);
            check("rst_data",  o_bcd_data,   16'hFFFF);
        end
        i_rst = 1'b0;
        step();
        check("first_grant",      16'(o_grant), 16'h0001);
        check("first_grant_data", o_bcd_data,   16'hFFFF);
        check("first_grant_busy", 16'(o_busy),  16'h0001);

        // Hold then preempt by source 1.
        i_req = 3'b011;
        step();
        check("src0_data",  o_bcd_data,   16'h1111);
        check("src0_valid", 16'(o_valid), 16'h0001);
        check("src0_grant", 16'(o_grant), 16'h0001);
        for (int i = 0; i < 6; i++) begin
            step();
            check("src0_hold", 16'(o_grant), 16'h0001);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            check("blank01_grant", 16'(o_grant), 16'h0000);
            check("blank01_data",  o_bcd_data,   16'hFFFF);
            check("blank01_valid", 16'(o_valid), 16'h0000);
            check("blank01_busy",  16'(o_busy),  16'h0001);
        end
        step();
        check("src1_grant", 16'(o_grant), 16'h0002);
        step();
        check("src1_data",  o_bcd_data,   16'h2222);
        check("src1_valid", 16'(o_valid), 16'h0001);
        step();
        check("src1_grant3", 16'(o_grant), 16'h0002);

        // Early release with nobody else waiting.
        i_req = 3'b000;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rel_blank_grant", 16'(o_grant), 16'h0000);
            check("rel_blank_busy",  16'(o_busy),  16'h0001);
        end
        step();
        check("rel_idle_busy",  16'(o_busy),  16'h0000);
        check("rel_idle_valid", 16'(o_valid), 16'h0000);
        check("rel_idle_data",  o_bcd_data,   16'hFFFF);
        step();
        check("rel_idle_stay", 16'(o_busy), 16'h0000);

        // Sole requester keeps the display well past the hold time.
        i_req = 3'b100;
        step();
        check("sole_grant", 16'(o_grant), 16'h0004);
        for (int i = 0; i < 50; i++) begin
            step();
            check("sole_keep", 16'(o_grant), 16'h0004);
            check("sole_data", o_bcd_data,   16'h3333);
            check("sole_busy", 16'(o_busy),  16'h0001);
        end

        // Round robin across all three sources.
        i_req = 3'b111;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rr_blank_in", 16'(o_grant), 16'h0000);
        end
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < ((r == 3) ? 1 : 8); i++) begin
                step();
                check("rr_owner", 16'(o_grant), 16'(rr_seq[r]));
            end
            if (r < 3) begin
                for (int i = 0; i < 2; i++) begin
                    step();
                    check("rr_blank", 16'(o_grant), 16'h0000);
                end
            end
        end

        // Source 2 granted, then source 0 asks during hold.
        i_req = 3'b100;
        for (int i = 0; i < 2; i++) begin
            step();
            check("pri_blank_in", 16'(o_grant), 16'h0000);
        end
        step();
        check("pri_src2_c1", 16'(o_grant), 16'h0004);
        step();
        check("pri_src2_c2", 16'(o_grant), 16'h0004);
        i_req = 3'b101;
`ifdef BCD_ARB_PRIORITY_EN
        for (int i = 0; i < 2; i++) begin
            step();
            check("pri_preempt_blank", 16'(o_grant), 16'h0000);
        end
        step();
        check("pri_src0", 16'(o_grant), 16'h0001);
`else
        for (int i = 0; i < 6; i++) begin
            step();
            check("pri_src2_hold", 16'(o_grant), 16'h0004);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            check("pri_blank", 16'(o_grant), 16'h0000);
        end
        step();
        check("pri_src0", 16'(o_grant), 16'h0001);
`endif

        // Reset mid-grant, then pointer restarts at source 0.
        i_rst = 1'b1;
        step();
        check("mid_rst_grant", 16'(o_grant), 16'h0000);
        check("mid_rst_busy",  16'(o_busy),  16'h0000);
        check("mid_rst_data",  o_bcd_data,   16'hFFFF);
        i_rst = 1'b0;
        i_req = 3'b110;
        step();
        check("mid_rst_regrant", 16'(o_grant), 16'h0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
